seg_scan_decoder: RTL

Receive-side counterpart of the two-digit seven-segment driver. It watches a multiplexed display bus, which is one shared segment bus plus a digit-select strobe, and debounces each digit until it is stable. It decodes the glyphs and reassembles the tens/units pair into a 4-bit value 0–15. It sits between a scanned display source, or a loop-back of our own display outputs, and any logic that needs the displayed number back in binary.

---
 rtl/seg_pkg.sv | 45 ++++
 rtl/seg_glyph_decode.sv | 33 +++
 rtl/seg_scan_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for seven-segment receivers: glyph patterns, error codes,
// digit-select encodings and the frame-assembly state type.
package seg_pkg;

   // Active-high segment patterns, bit6..0 = a,b,c,d,e,f,g
   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1110011;

   // Error causes reported on err_code
   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_GLYPH = 2'd1;
   localparam logic [1:0] ERR_RANGE = 2'd2;
   localparam logic [1:0] ERR_SEL   = 2'd3;

   // Digit-select encodings
   localparam logic [1:0] SEL_BLANK   = 2'b00;
   localparam logic [1:0] SEL_UNITS   = 2'b01;
   localparam logic [1:0] SEL_TENS    = 2'b10;
   localparam logic [1:0] SEL_ILLEGAL = 2'b11;

   typedef enum logic [0:0] {
      S_TENS  = 1'b0,
      S_UNITS = 1'b1
   } state_t;

   // True when the select strobes exactly one digit
   function automatic logic sel_is_onehot(input logic [1:0] sel);
      return (sel == SEL_UNITS) || (sel == SEL_TENS);
   endfunction

   // Reassemble tens/units into a 5-bit value (tens is 0 or 1, so max 19)
   function automatic logic [4:0] join_digits(input logic [3:0] tens,
                                              input logic [3:0] units);
      return ({1'b0, tens} * 5'd10) + {1'b0, units};
   endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational seven-segment glyph decoder: pattern -> {glyph_ok, digit}.
// Any pattern outside the ten decimal glyphs reports glyph_ok = 0, digit = 0.
module seg_glyph_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic       glyph_ok,
   output logic [3:0] digit
);

   // Map each recognised glyph to its decimal value
   always_comb begin
      glyph_ok = 1'b1;
      digit    = 4'd0;
      case (seg)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: begin
            glyph_ok = 1'b0;
            digit    = 4'd0;
         end
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a two-digit multiplexed seven-segment bus. Registers the
// bus, debounces each strobed digit, decodes the glyph and reassembles the
// tens/units pair into a 4-bit value, flagging glyph, range and select errors.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 2
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg,
   input  logic [1:0] dig_sel,
   output logic [3:0] num,
   output logic       num_valid,
   output logic       err,
   output logic [1:0] err_code
);

   // Counter value on the accepting cycle, and the value one cycle earlier
   localparam logic [3:0] ACCEPT_CNT = 4'(STABLE_CYCLES);
   localparam logic [3:0] ACCEPT_PRE = 4'(STABLE_CYCLES - 1);

   logic [6:0] seg_r;
   logic [1:0] sel_r;
   logic [6:0] seg_prev_r;
   logic [1:0] sel_prev_r;
   logic [3:0] cnt_r;
   logic [3:0] cnt_s;
   logic       accept_s;
   logic       glyph_ok_s;
   logic [3:0] digit_s;
   logic [4:0] value_s;
   state_t     state_r;
   state_t     state_s;
   logic [3:0] tens_r;
   logic [3:0] tens_s;
   logic [3:0] num_r;
   logic [3:0] num_s;
   logic       num_valid_r;
   logic       num_valid_s;
   logic       err_r;
   logic       err_s;
   logic [1:0] err_code_r;
   logic [1:0] err_code_s;

   // Capture the bus and keep one cycle of history for the stability compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r      <= 7'd0;
         sel_r      <= 2'b00;
         seg_prev_r <= 7'd0;
         sel_prev_r <= 2'b00;
      end else begin
         seg_r      <= seg;
         sel_r      <= dig_sel;
         seg_prev_r <= seg_r;
         sel_prev_r <= sel_r;
      end
   end

   // Next stability count and the single accept per uninterrupted hold
   always_comb begin
      cnt_s    = 4'd0;
      accept_s = 1'b0;
      if (sel_is_onehot(sel_r)) begin
         if ((seg_r == seg_prev_r) && (sel_r == sel_prev_r)) begin
            cnt_s    = (cnt_r == 4'd15) ? 4'd15 : (cnt_r + 4'd1);
            // Only the step into ACCEPT_CNT accepts; saturation never re-fires
            accept_s = (cnt_r == ACCEPT_PRE);
         end else begin
            cnt_s    = 4'd1;
            accept_s = (ACCEPT_CNT == 4'd1);
         end
      end else begin
         cnt_s    = 4'd0;
         accept_s = 1'b0;
      end
   end

   // Stability counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 4'd0;
      end else begin
         cnt_r <= cnt_s;
      end
   end

   seg_glyph_decode u_glyph (
      .seg      (seg_r),
      .glyph_ok (glyph_ok_s),
      .digit    (digit_s)
   );

   // Frame assembly: next state, stored tens and the output pulses
   always_comb begin
      state_s     = state_r;
      tens_s      = tens_r;
      num_s       = num_r;
      num_valid_s = 1'b0;
      err_s       = 1'b0;
      err_code_s  = err_code_r;
      value_s     = join_digits(tens_r, digit_s);
      if (sel_r == SEL_ILLEGAL) begin
         // No accept can coincide with an illegal select, so SEL wins outright
         err_s      = 1'b1;
         err_code_s = ERR_SEL;
         state_s    = S_TENS;
      end else if (accept_s && (sel_r == SEL_TENS)) begin
         if (!glyph_ok_s) begin
            err_s      = 1'b1;
            err_code_s = ERR_GLYPH;
            state_s    = S_TENS;
         end else if (digit_s <= 4'd1) begin
            tens_s  = digit_s;
            state_s = S_UNITS;
         end else begin
            err_s      = 1'b1;
            err_code_s = ERR_RANGE;
            state_s    = S_TENS;
         end
      end else if (accept_s && (sel_r == SEL_UNITS)) begin
         case (state_r)
            S_UNITS: begin
               state_s = S_TENS;
               if (!glyph_ok_s) begin
                  err_s      = 1'b1;
                  err_code_s = ERR_GLYPH;
               end else if (value_s <= 5'd15) begin
                  num_s       = value_s[3:0];
                  num_valid_s = 1'b1;
               end else begin
                  err_s      = 1'b1;
                  err_code_s = ERR_RANGE;
               end
            end
            S_TENS: begin
               // A units digit with no tens yet is dropped to resynchronise
               state_s = S_TENS;
            end
            default: begin
               state_s = S_TENS;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // FSM state, stored tens and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_TENS;
         tens_r      <= 4'd0;
         num_r       <= 4'd0;
         num_valid_r <= 1'b0;
         err_r       <= 1'b0;
         err_code_r  <= ERR_NONE;
      end else begin
         state_r     <= state_s;
         tens_r      <= tens_s;
         num_r       <= num_s;
         num_valid_r <= num_valid_s;
         err_r       <= err_s;
         err_code_r  <= err_code_s;
      end
   end

   assign num       = num_r;
   assign num_valid = num_valid_r;
   assign err       = err_r;
   assign err_code  = err_code_r;

endmodule
